// File: rtl/fifo_writer_packer_if.sv
// Byte-source, FIFO-write and status signals of the byte-to-word packer.
// The slave modport is the packer's view and the master modport is the environment's view.
interface fifo_writer_packer_if #(
  parameter int LEN_W = 6
);
  logic             Write_Request;
  logic [LEN_W-1:0] i_BUFFER_LENGTH;
  logic [7:0]       byte_in;
  logic             byte_in_valid;
  logic             byte_in_ready;
  logic             i_FIFO_full;
  logic [31:0]      o_FIFO_din;
  logic             o_FIFO_wr_en;
  logic             o_busy;
  logic             o_done;
  logic [1:0]       Pack_Counter;

  modport slave (
    input  Write_Request, i_BUFFER_LENGTH, byte_in, byte_in_valid, i_FIFO_full,
    output byte_in_ready, o_FIFO_din, o_FIFO_wr_en, o_busy, o_done, Pack_Counter
  );

  modport master (
    output Write_Request, i_BUFFER_LENGTH, byte_in, byte_in_valid, i_FIFO_full,
    input  byte_in_ready, o_FIFO_din, o_FIFO_wr_en, o_busy, o_done, Pack_Counter
  );
endinterface

// File: rtl/fifo_writer_packer.sv
// Packs a length-delimited byte stream little-endian into 32-bit FIFO words.
// Each word is written once it is full or holds the last byte, stalling while the FIFO is full.
module fifo_writer_packer #(
  parameter int LEN_W = 6
) (
  input  logic                 CLK,
  input  logic                 RESETn,
  fifo_writer_packer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, PACK, WRITE, DONE} state_t;

  state_t           state, state_nxt;
  logic [31:0]      word_reg;
  logic [1:0]       pack_cnt;
  logic [LEN_W-1:0] bytes_cnt;
  logic [LEN_W-1:0] length_reg;
  logic [LEN_W-1:0] bytes_inc;
  logic             start, accept, write;
  logic             ready, wr_en, done;

  assign bytes_inc = bytes_cnt + LEN_W'(1);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_nxt = state;
    start     = 1'b0;
    accept    = 1'b0;
    write     = 1'b0;
    ready     = 1'b0;
    wr_en     = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.Write_Request && (bus.i_BUFFER_LENGTH != '0)) begin
          start     = 1'b1;
          state_nxt = PACK;
        end
      end
      PACK: begin
        ready = 1'b1;
        if (bus.byte_in_valid) begin
          accept = 1'b1;
          if ((pack_cnt == 2'd3) || (bytes_inc == length_reg)) state_nxt = WRITE;
        end
      end
      WRITE: begin
        wr_en = !bus.i_FIFO_full;
        if (wr_en) begin
          write     = 1'b1;
          state_nxt = (bytes_cnt == length_reg) ? DONE : PACK;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Clearing the word on every write leaves the unused upper lanes of a partial final word at zero.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      word_reg   <= '0;
      pack_cnt   <= '0;
      bytes_cnt  <= '0;
      length_reg <= '0;
    end else if (start) begin
      // NOTE: all state registers use non-blocking assignments so every read sees the pre-edge value.
      word_reg   <= '0;
      pack_cnt   <= '0;
      bytes_cnt  <= '0;
      length_reg <= bus.i_BUFFER_LENGTH;
    end else if (accept) begin
      word_reg[{pack_cnt, 3'b000} +: 8] <= bus.byte_in;
      pack_cnt  <= pack_cnt + 2'd1;
      bytes_cnt <= bytes_inc;
    end else if (write) begin
      word_reg <= '0;
      pack_cnt <= '0;
    end
  end

  assign bus.byte_in_ready = ready;
  assign bus.o_FIFO_wr_en  = wr_en;
  assign bus.o_FIFO_din    = word_reg;
  assign bus.o_busy        = (state != IDLE);
  assign bus.o_done        = done;
  assign bus.Pack_Counter  = pack_cnt;

endmodule

// File: tb/tb_fifo_writer_packer.sv
// Bench for fifo_writer_packer: a table of packets with hand-computed words, hand-written corner cases,
// and random packets compared against a packing model built directly from the byte stream.
module tb_fifo_writer_packer;
  localparam int LEN_W = 6;

  logic CLK    = 1'b0;
  logic RESETn = 1'b0;
  always #5 CLK = ~CLK;

  fifo_writer_packer_if #(.LEN_W(LEN_W)) bus ();
  fifo_writer_packer #(.LEN_W(LEN_W)) dut (.CLK(CLK), .RESETn(RESETn), .bus(bus));

  int errors   = 0;
  int checks   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int fed      = 0;
  logic [31:0] wq[$];
  int          wcyc[$];
  logic [7:0]  pkt[$];

  typedef struct {
    int          len;
    logic [7:0]  base;
    int          mode;
    logic [31:0] first;
    logic [31:0] last;
    int          nwords;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Collects every FIFO write and o_done pulse, sampled mid-cycle.
  always @(negedge CLK) begin
    if (RESETn) begin
      if (bus.o_FIFO_wr_en) begin
        wq.push_back(bus.o_FIFO_din);
        wcyc.push_back(cyc);
      end
      if (bus.o_done) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy_in_done", 32'(bus.o_busy), 32'd1);
      end
    end
  end

  // Called at posedge+1; leaves the block in PACK at the following posedge+1.
  task automatic start_pkt(input int len);
    check("ready_before_req", 32'(bus.byte_in_ready), 32'd0);
    bus.Write_Request   = 1'b1;
    bus.i_BUFFER_LENGTH = LEN_W'(len);
    @(posedge CLK); #1;
    bus.Write_Request   = 1'b0;
    check("ready_after_req", 32'(bus.byte_in_ready), 32'd1);
    check("busy_after_req", 32'(bus.o_busy), 32'd1);
  endtask

  // mode 0: valid continuous, 1: valid pattern 1,0,0, 2: random valid.
  task automatic feed(input int n, input int mode, input bit rand_full);
    int got = 0;
    int t   = 0;
    bit v;
    bit acc;
    while (got < n && t < 600) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (t % 3 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus.byte_in_valid = v;
      bus.byte_in       = v ? pkt[fed] : 8'($urandom);
      if (rand_full) bus.i_FIFO_full = 1'($urandom_range(0, 1));
      if (bus.byte_in_ready) check("pack_lane", 32'(bus.Pack_Counter), 32'(fed % 4));
      acc = v && bus.byte_in_ready;
      @(posedge CLK); #1;
      if (acc) begin
        got++;
        fed++;
      end
      t++;
    end
    if (got < n) check("feed_timeout", 32'(got), 32'(n));
    bus.byte_in_valid = 1'b0;
  endtask

  task automatic wait_done(input bit rand_full);
    int d0 = done_cnt;
    int t  = 0;
    while (done_cnt == d0 && t < 300) begin
      bus.i_FIFO_full = rand_full ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge CLK); #1;
      t++;
    end
    bus.i_FIFO_full = 1'b0;
    if (done_cnt == d0) check("done_timeout", 32'(done_cnt), 32'(d0 + 1));
    check("busy_after_done", 32'(bus.o_busy), 32'd0);
  endtask

  // Sends pkt[0..len-1] and compares the written words with the packing model.
  task automatic run_pkt(input int len, input int mode, input bit rand_full);
    logic [31:0] exp[$];
    int d0;
    exp = {};
    for (int w = 0; w < (len + 3) / 4; w++) exp.push_back(32'd0);
    for (int i = 0; i < len; i++) exp[i / 4] = exp[i / 4] | (32'(pkt[i]) << (8 * (i % 4)));
    wq.delete();
    wcyc.delete();
    fed = 0;
    d0  = done_cnt;
    start_pkt(len);
    feed(len, mode, rand_full);
    wait_done(rand_full);
    check("word_count", 32'(wq.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < wq.size(); i++) check("word", wq[i], exp[i]);
    check("done_pulses", 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic fill_ramp(input int len, input logic [7:0] base);
    pkt.delete();
    for (int i = 0; i < len; i++) pkt.push_back(base + 8'(i));
  endtask

  initial begin
    int d0;
    int len;

    vecs[0] = '{8,  8'h01, 0, 32'h04030201, 32'h08070605, 2};
    vecs[1] = '{5,  8'hA0, 0, 32'hA3A2A1A0, 32'h000000A4, 2};
    vecs[2] = '{6,  8'h30, 1, 32'h33323130, 32'h00003534, 2};
    vecs[3] = '{1,  8'h55, 2, 32'h00000055, 32'h00000055, 1};
    vecs[4] = '{63, 8'h00, 0, 32'h03020100, 32'h003E3D3C, 16};
    vecs[5] = '{4,  8'hC0, 1, 32'hC3C2C1C0, 32'hC3C2C1C0, 1};

    bus.Write_Request   = 1'b0;
    bus.i_BUFFER_LENGTH = '0;
    bus.byte_in         = '0;
    bus.byte_in_valid   = 1'b0;
    bus.i_FIFO_full     = 1'b0;

    // Reset values
    #3;
    check("rst_ready", 32'(bus.byte_in_ready), 32'd0);
    check("rst_wr_en", 32'(bus.o_FIFO_wr_en), 32'd0);
    check("rst_din", bus.o_FIFO_din, 32'd0);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    check("rst_done", 32'(bus.o_done), 32'd0);
    check("rst_pack", 32'(bus.Pack_Counter), 32'd0);
    @(negedge CLK); #1;
    RESETn = 1'b1;
    @(posedge CLK); #1;

    // Table of packets with hand-computed first/last words
    foreach (vecs[v]) begin
      fill_ramp(vecs[v].len, vecs[v].base);
      run_pkt(vecs[v].len, vecs[v].mode, 1'b0);
      check("tbl_nwords", 32'(wq.size()), 32'(vecs[v].nwords));
      if (wq.size() > 0) begin
        check("tbl_first", wq[0], vecs[v].first);
        check("tbl_last", wq[wq.size() - 1], vecs[v].last);
      end
    end

    // Throughput: L=8 writes 5 cycles apart, o_done one cycle after the last write
    fill_ramp(8, 8'h01);
    run_pkt(8, 0, 1'b0);
    if (wcyc.size() == 2) begin
      check("write_spacing", 32'(wcyc[1] - wcyc[0]), 32'd5);
      check("done_latency", 32'(done_cyc - wcyc[1]), 32'd1);
    end else begin
      check("write_cycles_seen", 32'(wcyc.size()), 32'd2);
    end

    // FIFO full for 3 cycles on entering WRITE
    fill_ramp(4, 8'h10);
    wq.delete();
    fed = 0;
    bus.i_FIFO_full = 1'b1;
    start_pkt(4);
    feed(4, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("stall_wr_en", 32'(bus.o_FIFO_wr_en), 32'd0);
      check("stall_din", bus.o_FIFO_din, 32'h13121110);
      check("stall_ready", 32'(bus.byte_in_ready), 32'd0);
      @(posedge CLK); #1;
    end
    bus.i_FIFO_full = 1'b0;
    @(negedge CLK);
    check("stall_release_wr_en", 32'(bus.o_FIFO_wr_en), 32'd1);
    @(posedge CLK); #1;
    wait_done(1'b0);
    check("stall_nwords", 32'(wq.size()), 32'd1);
    if (wq.size() > 0) check("stall_word", wq[0], 32'h13121110);

    // Zero-length request is ignored
    wq.delete();
    d0 = done_cnt;
    bus.Write_Request   = 1'b1;
    bus.i_BUFFER_LENGTH = '0;
    @(posedge CLK); #1;
    bus.Write_Request = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("len0_busy", 32'(bus.o_busy), 32'd0);
      check("len0_ready", 32'(bus.byte_in_ready), 32'd0);
      @(posedge CLK); #1;
    end
    check("len0_writes", 32'(wq.size()), 32'd0);
    check("len0_done", 32'(done_cnt - d0), 32'd0);

    // Second request mid-packet keeps the original length
    fill_ramp(8, 8'h40);
    wq.delete();
    fed = 0;
    d0  = done_cnt;
    start_pkt(8);
    feed(2, 0, 1'b0);
    bus.Write_Request   = 1'b1;
    bus.i_BUFFER_LENGTH = LEN_W'(3);
    feed(6, 0, 1'b0);
    bus.Write_Request = 1'b0;
    wait_done(1'b0);
    check("midreq_nwords", 32'(wq.size()), 32'd2);
    if (wq.size() == 2) begin
      check("midreq_w0", wq[0], 32'h43424140);
      check("midreq_w1", wq[1], 32'h47464544);
    end
    check("midreq_done", 32'(done_cnt - d0), 32'd1);

    // Reset after 2 bytes of an L=8 packet aborts immediately
    fill_ramp(8, 8'h01);
    wq.delete();
    fed = 0;
    d0  = done_cnt;
    start_pkt(8);
    feed(2, 0, 1'b0);
    RESETn = 1'b0;
    #1;
    check("abort_ready", 32'(bus.byte_in_ready), 32'd0);
    check("abort_busy", 32'(bus.o_busy), 32'd0);
    check("abort_pack", 32'(bus.Pack_Counter), 32'd0);
    check("abort_din", bus.o_FIFO_din, 32'd0);
    check("abort_wr_en", 32'(bus.o_FIFO_wr_en), 32'd0);
    @(negedge CLK); #1;
    RESETn = 1'b1;
    @(posedge CLK); #1;
    check("abort_writes", 32'(wq.size()), 32'd0);
    check("abort_done", 32'(done_cnt - d0), 32'd0);
    fill_ramp(4, 8'hE0);
    run_pkt(4, 0, 1'b0);
    if (wq.size() > 0) check("post_abort_word", wq[0], 32'hE3E2E1E0);

    // Reset during the write cycle drops o_FIFO_wr_en at once
    fill_ramp(4, 8'h70);
    wq.delete();
    fed = 0;
    d0  = done_cnt;
    start_pkt(4);
    feed(4, 0, 1'b0);
    check("wr_cycle_wr_en", 32'(bus.o_FIFO_wr_en), 32'd1);
    RESETn = 1'b0;
    #1;
    check("wr_cycle_rst_wr_en", 32'(bus.o_FIFO_wr_en), 32'd0);
    @(negedge CLK); #1;
    RESETn = 1'b1;
    @(posedge CLK); #1;
    check("wr_cycle_rst_writes", 32'(wq.size()), 32'd0);
    check("wr_cycle_rst_done", 32'(done_cnt - d0), 32'd0);

    // Random packets, random valid and random FIFO backpressure
    for (int r = 0; r < 25; r++) begin
      len = $urandom_range(1, 63);
      pkt.delete();
      for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
      run_pkt(len, 2, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
